// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator with sync, visibility, character-cell look-ahead and blink phase
//   clk, rst          dot clock, synchronous active-high reset
//   hSync, vSync      sync pulses, asserted level H_SYNC_POL / V_SYNC_POL
//   vis, hCount, vCount, lineStart, frameStart   raster position and strobes
//   fetchActive, fetchCol, fetchRow, fetchLine, fetchPix   cell coordinates FETCH_LEAD pixels ahead
//   blink             toggles every BLINK_FRAMES frames
module vga_timing_gen #(
  parameter int H_VIS = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_VIS = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int CHAR_W = 8,
  parameter int CHAR_H = 16,
  parameter int FETCH_LEAD = 3,
  parameter int BLINK_FRAMES = 16,
  parameter int CW = 12
) (
  input  logic          clk,
  input  logic          rst,
  output logic          hSync,
  output logic          vSync,
  output logic          vis,
  output logic [CW-1:0] hCount,
  output logic [CW-1:0] vCount,
  output logic          lineStart,
  output logic          frameStart,
  output logic          fetchActive,
  output logic [7:0]    fetchCol,
  output logic [6:0]    fetchRow,
  output logic [3:0]    fetchLine,
  output logic [2:0]    fetchPix,
  output logic          blink
);
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_V = CW'(H_VIS);
  localparam logic [CW-1:0] V_V = CW'(V_VIS);
  localparam logic [CW-1:0] HS_B = CW'(H_VIS + H_FP);
  localparam logic [CW-1:0] HS_E = CW'(H_VIS + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_B = CW'(V_VIS + V_FP);
  localparam logic [CW-1:0] VS_E = CW'(V_VIS + V_FP + V_SYNC);
  localparam logic [CW-1:0] LEAD = CW'(FETCH_LEAD);
  localparam logic [2:0] PIX_MAX = 3'(CHAR_W - 1);
  localparam logic [3:0] LINE_MAX = 4'(CHAR_H - 1);
  localparam logic [2:0] INIT_PIX = FETCH_LEAD < H_VIS ? 3'(FETCH_LEAD % CHAR_W) : 3'd0;
  localparam logic [7:0] INIT_COL = FETCH_LEAD < H_VIS ? 8'(FETCH_LEAD / CHAR_W) : 8'd0;
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic HP = H_SYNC_POL != 0;
  localparam logic VP = V_SYNC_POL != 0;
  if (H_VIS % CHAR_W != 0 || V_VIS % CHAR_H != 0 || FETCH_LEAD < 1 ||
      FETCH_LEAD > H_FP + H_SYNC + H_BP || BLINK_FRAMES < 1) begin : g_bad_param
    $error("vga_timing_gen: invalid parameter combination");
  end
  // run is low for the first clock after reset so that the first running cycle shows (0,0)
  logic run, lineAdv, fa, nFrame;
  logic [CW-1:0] nh, nv, ph, pv, nph, npv;
  logic [2:0] pix, npix;
  logic [7:0] col, ncol;
  logic [3:0] line, nline;
  logic [6:0] row, nrow;
  logic [BW-1:0] bcnt;
  // ph/pv track the look-ahead pixel; cell counters advance only inside the visible area
  // and are cleared when the look-ahead wraps line (columns) or frame (rows)
  always_comb begin
    nh = !run || hCount == H_LAST ? '0 : hCount + 1'b1;
    nv = !run ? '0 : hCount != H_LAST ? vCount : vCount == V_LAST ? '0 : vCount + 1'b1;
    nph = !run ? LEAD : ph == H_LAST ? '0 : ph + 1'b1;
    npv = !run ? '0 : ph != H_LAST ? pv : pv == V_LAST ? '0 : pv + 1'b1;
    lineAdv = run && ph == H_LAST;
    npix = !run ? INIT_PIX : nph == '0 ? '0 : nph >= H_V ? pix : pix == PIX_MAX ? '0 : pix + 1'b1;
    ncol = !run ? INIT_COL : nph == '0 ? '0 : nph >= H_V || pix != PIX_MAX ? col : col + 1'b1;
    nline = !run || (lineAdv && npv == '0) ? '0 :
            !lineAdv || npv >= V_V ? line : line == LINE_MAX ? '0 : line + 1'b1;
    nrow = !run || (lineAdv && npv == '0) ? '0 :
           !lineAdv || npv >= V_V || line != LINE_MAX ? row : row + 1'b1;
    fa = nph < H_V && npv < V_V;
    nFrame = nh == '0 && nv == '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      run <= 1'b0;
      hCount <= '0;
      vCount <= '0;
      hSync <= ~HP;
      vSync <= ~VP;
      vis <= 1'b0;
      lineStart <= 1'b0;
      frameStart <= 1'b0;
      ph <= '0;
      pv <= '0;
      pix <= '0;
      col <= '0;
      line <= '0;
      row <= '0;
      fetchActive <= 1'b0;
      fetchPix <= '0;
      fetchCol <= '0;
      fetchLine <= '0;
      fetchRow <= '0;
      bcnt <= '0;
      blink <= 1'b0;
    end else begin
      run <= 1'b1;
      hCount <= nh;
      vCount <= nv;
      hSync <= nh >= HS_B && nh < HS_E ? HP : ~HP;
      vSync <= nv >= VS_B && nv < VS_E ? VP : ~VP;
      vis <= nh < H_V && nv < V_V;
      lineStart <= nh == '0;
      frameStart <= nFrame;
      ph <= nph;
      pv <= npv;
      pix <= npix;
      col <= ncol;
      line <= nline;
      row <= nrow;
      fetchActive <= fa;
      fetchPix <= fa ? npix : '0;
      fetchCol <= fa ? ncol : '0;
      fetchLine <= fa ? nline : '0;
      fetchRow <= fa ? nrow : '0;
      if (nFrame) begin
        bcnt <= bcnt == B_LAST ? '0 : bcnt + 1'b1;
        blink <= bcnt == B_LAST ? ~blink : blink;
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks three vga_timing_gen configurations against an arithmetic raster model
module tb_vga_timing_gen;
  localparam int NI = 3;
  localparam int P_HV [NI] = '{640, 16, 16};
  localparam int P_HF [NI] = '{16, 2, 2};
  localparam int P_HS [NI] = '{96, 3, 3};
  localparam int P_HB [NI] = '{48, 3, 3};
  localparam int P_VV [NI] = '{48, 4, 4};
  localparam int P_VF [NI] = '{2, 1, 1};
  localparam int P_VS [NI] = '{2, 1, 1};
  localparam int P_VB [NI] = '{3, 1, 1};
  localparam int P_HP [NI] = '{0, 1, 0};
  localparam int P_VP [NI] = '{0, 1, 1};
  localparam int P_CW [NI] = '{8, 8, 4};
  localparam int P_CH [NI] = '{16, 4, 2};
  localparam int P_FL [NI] = '{3, 5, 8};
  localparam int P_BF [NI] = '{16, 2, 1};
  localparam int FRAME0 = 800 * 55;
  localparam int FRAME1 = 24 * 7;

  typedef struct packed {
    logic [11:0] hc;
    logic [11:0] vc;
    logic hs, vs, vis, ls, fs, fa;
    logic [7:0] col;
    logic [6:0] row;
    logic [3:0] line;
    logic [2:0] pix;
    logic bl;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  out_t act [NI];
  out_t exp_o [NI];
  int t = -1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [11:0] hc, vc;
    logic hs, vs, vi, ls, fs, fa, bl;
    logic [7:0] col;
    logic [6:0] row;
    logic [3:0] ln;
    logic [2:0] px;
    vga_timing_gen #(
      .H_VIS(P_HV[g]), .H_FP(P_HF[g]), .H_SYNC(P_HS[g]), .H_BP(P_HB[g]),
      .V_VIS(P_VV[g]), .V_FP(P_VF[g]), .V_SYNC(P_VS[g]), .V_BP(P_VB[g]),
      .H_SYNC_POL(P_HP[g]), .V_SYNC_POL(P_VP[g]), .CHAR_W(P_CW[g]), .CHAR_H(P_CH[g]),
      .FETCH_LEAD(P_FL[g]), .BLINK_FRAMES(P_BF[g]), .CW(12)
    ) u_dut (
      .clk(clk), .rst(rst), .hSync(hs), .vSync(vs), .vis(vi), .hCount(hc), .vCount(vc),
      .lineStart(ls), .frameStart(fs), .fetchActive(fa), .fetchCol(col), .fetchRow(row),
      .fetchLine(ln), .fetchPix(px), .blink(bl)
    );
    assign act[g] = {hc, vc, hs, vs, vi, ls, fs, fa, col, row, ln, px, bl};
  end

  // t counts running cycles since reset release (-1 while held in reset)
  function automatic out_t model(input int i, input int tt);
    out_t e;
    int ht, vt, h, v, q, ph, pv, n;
    ht = P_HV[i] + P_HF[i] + P_HS[i] + P_HB[i];
    vt = P_VV[i] + P_VF[i] + P_VS[i] + P_VB[i];
    e = '0;
    e.hs = P_HP[i] == 0;
    e.vs = P_VP[i] == 0;
    if (tt < 0) return e;
    h = tt % ht;
    v = (tt / ht) % vt;
    e.hc = 12'(h);
    e.vc = 12'(v);
    e.hs = (h >= P_HV[i] + P_HF[i] && h < P_HV[i] + P_HF[i] + P_HS[i]) ^ (P_HP[i] == 0);
    e.vs = (v >= P_VV[i] + P_VF[i] && v < P_VV[i] + P_VF[i] + P_VS[i]) ^ (P_VP[i] == 0);
    e.vis = h < P_HV[i] && v < P_VV[i];
    e.ls = h == 0;
    e.fs = tt % (ht * vt) == 0;
    q = tt + P_FL[i];
    ph = q % ht;
    pv = (q / ht) % vt;
    if (ph < P_HV[i] && pv < P_VV[i]) begin
      e.fa = 1'b1;
      e.col = 8'(ph / P_CW[i]);
      e.pix = 3'(ph % P_CW[i]);
      e.row = 7'(pv / P_CH[i]);
      e.line = 4'(pv % P_CH[i]);
    end
    n = tt / (ht * vt) + 1;
    e.bl = (n / P_BF[i]) % 2 == 1;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    t = rst ? -1 : t + 1;
    #1;
    for (int i = 0; i < NI; i++) exp_o[i] = model(i, t);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (act[i] !== exp_o[i]) begin
        errors++;
        $display("FAIL reset_state dut%0d got %h expected %h", i, act[i], exp_o[i]);
      end
    end
    checks++;
    if (act[0].hs !== 1'b1 || act[1].hs !== 1'b0 || act[2].vs !== 1'b0) begin
      errors++;
      $display("FAIL reset_sync_pol got hs0=%b hs1=%b vs2=%b expected 1 0 0", act[0].hs, act[1].hs, act[2].vs);
    end
  endtask

  task automatic test_frames();
    bit bad [NI] = '{0, 0, 0};
    int visCnt = 0, hsCnt = 0, vsCnt = 0;
    logic prevFa = 1'b0;
    rst = 1'b0;
    for (int c = 0; c < FRAME0 + 10; c++) begin
      step();
      for (int i = 0; i < NI; i++) begin
        if (!bad[i]) begin
          checks++;
          if (act[i] !== exp_o[i]) begin
            errors++;
            bad[i] = 1;
            $display("FAIL frame_sweep dut%0d t=%0d got %h expected %h", i, t, act[i], exp_o[i]);
          end
        end
      end
      if (t < FRAME0) begin
        visCnt += int'(act[0].vis);
        hsCnt += int'(!act[0].hs);
        vsCnt += int'(!act[0].vs);
      end
      if (t < 24) begin
        checks++;
        if (act[1].hs !== (t >= 18 && t <= 20)) begin
          errors++;
          $display("FAIL small_hsync t=%0d got %b expected %b", t, act[1].hs, t >= 18 && t <= 20);
        end
      end
      if (t == 54 * 800 + 797) begin
        checks++;
        if (act[0].fa !== 1'b1 || prevFa !== 1'b0 || act[0].col !== 8'd0 || act[0].row !== 7'd0 || act[0].line !== 4'd0) begin
          errors++;
          $display("FAIL fetch_rise got fa=%b prev=%b col=%0d row=%0d line=%0d expected 1 0 0 0 0",
                   act[0].fa, prevFa, act[0].col, act[0].row, act[0].line);
        end
      end
      if (t == 10 * 800 + 637) begin
        checks++;
        if (act[0].fa !== 1'b0 || prevFa !== 1'b1 || act[0].vis !== 1'b1) begin
          errors++;
          $display("FAIL fetch_fall got fa=%b prev=%b vis=%b expected 0 1 1", act[0].fa, prevFa, act[0].vis);
        end
      end
      if (t == 47 * 800 + 636) begin
        checks++;
        if (act[0].col !== 8'd79 || act[0].row !== 7'd2 || act[0].line !== 4'd15 || act[0].pix !== 3'd7) begin
          errors++;
          $display("FAIL cell_last got col=%0d row=%0d line=%0d pix=%0d expected 79 2 15 7",
                   act[0].col, act[0].row, act[0].line, act[0].pix);
        end
      end
      if (t == 16 * 800 + 5) begin
        checks++;
        if (act[0].col !== 8'd1 || act[0].row !== 7'd1 || act[0].line !== 4'd0 || act[0].pix !== 3'd0) begin
          errors++;
          $display("FAIL cell_8_16 got col=%0d row=%0d line=%0d pix=%0d expected 1 1 0 0",
                   act[0].col, act[0].row, act[0].line, act[0].pix);
        end
      end
      prevFa = act[0].fa;
    end
    checks++;
    if (visCnt != 640 * 48 || hsCnt != 96 * 55 || vsCnt != 2 * 800) begin
      errors++;
      $display("FAIL frame_counts got vis=%0d hs=%0d vs=%0d expected %0d %0d %0d",
               visCnt, hsCnt, vsCnt, 640 * 48, 96 * 55, 2 * 800);
    end
  endtask

  task automatic test_blink();
    logic expBl [6] = '{0, 1, 1, 0, 0, 1};
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 6 * FRAME1 + 2; c++) begin
      step();
      if (t % FRAME1 == 0 && t / FRAME1 < 6) begin
        checks++;
        if (act[1].fs !== 1'b1 || act[1].bl !== expBl[t / FRAME1]) begin
          errors++;
          $display("FAIL blink frame%0d got fs=%b blink=%b expected 1 %b", t / FRAME1 + 1, act[1].fs, act[1].bl, expBl[t / FRAME1]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c <= 5 * 800 + 300; c++) step();
    checks++;
    if (act[0].hc !== 12'd300 || act[0].vc !== 12'd5 || act[1].bl !== 1'b1) begin
      errors++;
      $display("FAIL midframe_pre got h=%0d v=%0d bl1=%b expected 300 5 1", act[0].hc, act[0].vc, act[1].bl);
    end
    rst = 1'b1;
    step();
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (act[i] !== exp_o[i]) begin
        errors++;
        $display("FAIL midframe_reset dut%0d got %h expected %h", i, act[i], exp_o[i]);
      end
    end
    rst = 1'b0;
    step();
    checks++;
    if (act[0].hc !== 12'd0 || act[0].vc !== 12'd0 || act[0].ls !== 1'b1 || act[0].fs !== 1'b1 ||
        act[0].hs !== 1'b1 || act[0].vs !== 1'b1 || act[0].vis !== 1'b1 || act[1].bl !== 1'b0) begin
      errors++;
      $display("FAIL midframe_restart got h=%0d v=%0d ls=%b fs=%b hs=%b vs=%b vis=%b bl1=%b expected 0 0 1 1 1 1 1 0",
               act[0].hc, act[0].vc, act[0].ls, act[0].fs, act[0].hs, act[0].vs, act[0].vis, act[1].bl);
    end
  endtask

  task automatic test_random_resets();
    bit bad [NI] = '{0, 0, 0};
    int runLen, rstLen;
    for (int k = 0; k < 4; k++) begin
      runLen = $urandom_range(1, 2000);
      rstLen = $urandom_range(1, 3);
      for (int c = 0; c < runLen + rstLen; c++) begin
        rst = c >= runLen;
        step();
        for (int i = 0; i < NI; i++) begin
          if (!bad[i]) begin
            checks++;
            if (act[i] !== exp_o[i]) begin
              errors++;
              bad[i] = 1;
              $display("FAIL random_reset dut%0d t=%0d got %h expected %h", i, t, act[i], exp_o[i]);
            end
          end
        end
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 200; c++) begin
      step();
      for (int i = 0; i < NI; i++) begin
        if (!bad[i]) begin
          checks++;
          if (act[i] !== exp_o[i]) begin
            errors++;
            bad[i] = 1;
            $display("FAIL random_reset_tail dut%0d t=%0d got %h expected %h", i, t, act[i], exp_o[i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_blink();
    test_reset_midframe();
    test_random_resets();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
